pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter and decides the next fetch address each cycle: sequential PC+4, taken conditional branch, j/jal, jr, or address-error vector.
- Consumes the combinational is_branch decision from the branch-compare unit and the decoded instruction fields.
- Drives the fetch address, plus a flush window for the pipelined core variant.
- Keeps wrap-around counters of taken redirects for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on a misaligned jr target.
- FLUSH_CYCLES, 1, number of cycles flush stays high after a redirect (legal range 1..7).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hazard stall; freezes all state.
- instr_valid  in  1  the current instruction fields are valid and may redirect.
- op_code  in  6  instruction [31:26].
- funct  in  6  instruction [5:0] (jr detection).
- is_branch  in  1  conditional-branch taken decision for the current instruction.
- imm16  in  16  branch offset, in words.
- jidx  in  26  jump index.
- rs_val  in  32  register rs value (jr target).
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc+4, combinational from pc.
- flush  out  1  squash younger instructions.
- addr_err  out  1  one-cycle pulse on a misaligned jr target.
- redirect_cnt  out  16  count of taken redirects.

Behaviour:
- Reset, with rst sampled at the posedge: pc=RESET_PC, state=RUN, flush=0, addr_err=0, redirect_cnt=0, internal flush counter=0. rst overrides stall and all other inputs, including during REDIRECT.
- States:
  - RUN: normal sequencing.
  - REDIRECT: flush window active.
- Control classes (decoded from op_code):
  - Conditional branches: 000100, 000101, 000001, 000110, 000111. These are taken only when is_branch=1.
  - j = 000010 and jal = 000011: always taken.
  - jr: op_code=000000 and funct=001000. Always taken.
- Target computation, all in 32-bit modulo arithmetic:
  - Branch target: pc_plus4 + ({{14{imm16[15]}},imm16,2'b00}).
  - Jump target: {pc_plus4[31:28], jidx, 2'b00}.
  - jr target: rs_val.
- Each cycle with stall=0 in RUN:
  - If instr_valid=1 and a taken control is present, go to step A; otherwise pc<=pc_plus4 and state stays RUN.
  - Step A: if it is a jr with rs_val[1:0]!=0, then pc<=EXC_VECTOR and addr_err=1 for exactly that next cycle. Otherwise pc<=target.
  - Step B (after A): redirect_cnt += 1 (wraps 16'hFFFF->0), state<=REDIRECT, flush counter<=FLUSH_CYCLES.
- flush is a registered output, high whenever state=REDIRECT.
- In REDIRECT with stall=0:
  - pc<=pc_plus4.
  - Control inputs are ignored, because those instructions are being squashed.
  - The counter decrements. When it reaches 1 it is cleared and state<=RUN, so flush is high for exactly FLUSH_CYCLES unstalled cycles.
- stall=1: pc, state, flush counter and redirect_cnt hold. flush holds its value. addr_err is a pulse and still clears after one cycle.
- Latency: a redirect is visible on pc one clock after the deciding cycle. There is no combinational path from inputs to pc.
- Non-taken conditional branch (is_branch=0): behaves as sequential, no flush, counter unchanged.
- A conditional-branch op with instr_valid=0 is ignored.

Decomposition:
- Shared package (core_pkg) holds:
  - Opcode constants OP_RTYPE, OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL, and FUNCT_JR.
  - The state encoding typedef {RUN, REDIRECT}.
- One natural sub-module: pc_target_calc, purely combinational. It produces the branch, jump and jr targets plus the misalign flag. The FSM, PC register and counters stay in pc_sequencer.

Test Plan:
- Reset release, 4 unstalled cycles, no control ops -> pc = 0x0, 0x4, 0x8, 0xC, 0x10; flush=0; redirect_cnt=0.
- At pc=0x100, op 000100, is_branch=1, imm16=16'hFFFC -> next pc=0xF4, flush=1 for 1 cycle, then pc=0xF8, redirect_cnt=1. Repeat with is_branch=0 -> pc=0x104, no flush.
- At pc=0x3000_0010, op 000010, jidx=26'h0000040 -> pc=0x3000_0100. With FLUSH_CYCLES=3: flush high for 3 cycles and a control op during them is ignored.
- jr with rs_val=0x0000_2002 -> pc=EXC_VECTOR (0x80), addr_err pulses 1 cycle, flush=1. Then jr with rs_val=0x2000 -> pc=0x2000, addr_err=0.
- Stall held for 3 cycles mid-REDIRECT -> pc and flush frozen, addr_err clears. After release the remaining flush cycles complete.
- rst asserted in REDIRECT together with stall=1 -> next cycle pc=RESET_PC, flush=0, redirect_cnt=0.
- Preset redirect_cnt=16'hFFFF via 65535 taken branches, then one more taken branch -> redirect_cnt=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: control opcodes, sequencer state encoding and target bundle.
package core_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned JIDX_W   = 26;

    localparam logic [OP_W-1:0] OP_RTYPE  = 6'b000000;
    localparam logic [OP_W-1:0] OP_REGIMM = 6'b000001;
    localparam logic [OP_W-1:0] OP_J      = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL    = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ    = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE    = 6'b000101;
    localparam logic [OP_W-1:0] OP_BLEZ   = 6'b000110;
    localparam logic [OP_W-1:0] OP_BGTZ   = 6'b000111;
    localparam logic [OP_W-1:0] FUNCT_JR  = 6'b001000;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } seq_state_t;

    typedef struct packed {
        logic [XLEN-1:0] br_target;
        logic [XLEN-1:0] j_target;
        logic [XLEN-1:0] jr_target;
        logic            jr_misalign;
    } pc_targets_t;

    function automatic logic is_cond_branch(input logic [OP_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_REGIMM) ||
               (op == OP_BLEZ) || (op == OP_BGTZ);
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target generation for branch, jump and jr.
module pc_target_calc
    import core_pkg::*;
(
    input  logic [XLEN-1:0]   pc_plus4,
    input  logic [IMM_W-1:0]  imm16,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [XLEN-1:0]   rs_val,
    output pc_targets_t       targets_c
);

    always_comb begin
        targets_c.br_target   = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
        targets_c.j_target    = {pc_plus4[31:28], jidx, 2'b00};
        targets_c.jr_target   = rs_val;
        targets_c.jr_misalign = |rs_val[1:0];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: picks the next fetch address and drives the post-redirect flush window.
module pc_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              instr_valid,
    input  logic [OP_W-1:0]   op_code,
    input  logic [OP_W-1:0]   funct,
    input  logic              is_branch,
    input  logic [IMM_W-1:0]  imm16,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [XLEN-1:0]   rs_val,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              flush,
    output logic              addr_err,
    output logic [15:0]       redirect_cnt
);

    localparam int unsigned FCNT_W = 3;
    localparam int unsigned RCNT_W = 16;

    seq_state_t        state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [XLEN-1:0]   pc_d;
    logic              flush_d;
    logic              addr_err_d;
    logic [RCNT_W-1:0] rcnt_d;

    pc_targets_t       targets_c;
    logic              is_jump_c;
    logic              is_jr_c;
    logic              taken_c;
    logic [XLEN-1:0]   target_c;

    assign pc_plus4 = pc + 32'd4;

    pc_target_calc u_target_calc (
        .pc_plus4  (pc_plus4),
        .imm16     (imm16),
        .jidx      (jidx),
        .rs_val    (rs_val),
        .targets_c (targets_c)
    );

    // Control-class decode and target selection
    always_comb begin
        is_jump_c = (op_code == OP_J) || (op_code == OP_JAL);
        is_jr_c   = (op_code == OP_RTYPE) && (funct == FUNCT_JR);
        taken_c   = instr_valid &&
                    (is_jump_c || is_jr_c || (is_cond_branch(op_code) && is_branch));
        if (is_jr_c)        target_c = targets_c.jr_target;
        else if (is_jump_c) target_c = targets_c.j_target;
        else                target_c = targets_c.br_target;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        pc_d       = pc;
        flush_d    = flush;
        rcnt_d     = redirect_cnt;
        addr_err_d = 1'b0;

        if (!stall) begin
            case (state_q)
                RUN: begin
                    pc_d    = pc_plus4;
                    flush_d = 1'b0;
                    if (taken_c) begin
                        if (is_jr_c && targets_c.jr_misalign) begin
                            pc_d       = EXC_VECTOR;
                            addr_err_d = 1'b1;
                        end else begin
                            pc_d = target_c;
                        end
                        rcnt_d  = redirect_cnt + 16'd1;
                        state_d = REDIRECT;
                        fcnt_d  = FCNT_W'(FLUSH_CYCLES);
                        flush_d = 1'b1;
                    end
                end
                REDIRECT: begin
                    pc_d = pc_plus4;
                    if (fcnt_q <= FCNT_W'(1)) begin
                        fcnt_d  = '0;
                        state_d = RUN;
                        flush_d = 1'b0;
                    end else begin
                        fcnt_d = fcnt_q - FCNT_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    flush_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            fcnt_q       <= '0;
            pc           <= RESET_PC;
            flush        <= 1'b0;
            addr_err     <= 1'b0;
            redirect_cnt <= '0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            pc           <= pc_d;
            flush        <= flush_d;
            addr_err     <= addr_err_d;
            redirect_cnt <= rcnt_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one instance with a 1-cycle flush window, one with 3.
module tb_pc_sequencer;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall, valid1, valid3, is_branch;
    logic [5:0]  op_code, funct;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic [31:0] rs_val;

    logic [31:0] pc1, pc_plus4_1, pc3, pc_plus4_3;
    logic        flush1, addr_err1, flush3, addr_err3;
    logic [15:0] rcnt1, rcnt3;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer dut1 (
        .clk(clk), .rst(rst), .stall(stall), .instr_valid(valid1),
        .op_code(op_code), .funct(funct), .is_branch(is_branch),
        .imm16(imm16), .jidx(jidx), .rs_val(rs_val),
        .pc(pc1), .pc_plus4(pc_plus4_1), .flush(flush1),
        .addr_err(addr_err1), .redirect_cnt(rcnt1)
    );

    pc_sequencer #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .stall(stall), .instr_valid(valid3),
        .op_code(op_code), .funct(funct), .is_branch(is_branch),
        .imm16(imm16), .jidx(jidx), .rs_val(rs_val),
        .pc(pc3), .pc_plus4(pc_plus4_3), .flush(flush3),
        .addr_err(addr_err3), .redirect_cnt(rcnt3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic v3, input logic [5:0] op,
                         input logic [5:0] fn, input logic br, input logic [15:0] imm,
                         input logic [25:0] ji, input logic [31:0] rs);
        valid1 = v1; valid3 = v3; op_code = op; funct = fn;
        is_branch = br; imm16 = imm; jidx = ji; rs_val = rs;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    endtask

    // Common checks on both instances
    task automatic check_both(input string tag, input logic [31:0] exp_pc,
                              input logic exp_f1, input logic exp_f3, input logic [15:0] exp_cnt);
        check({tag, ".pc1"}, pc1, exp_pc);
        check({tag, ".pc3"}, pc3, exp_pc);
        check({tag, ".flush1"}, 32'(flush1), 32'(exp_f1));
        check({tag, ".flush3"}, 32'(flush3), 32'(exp_f3));
        check({tag, ".cnt1"}, 32'(rcnt1), 32'(exp_cnt));
        check({tag, ".cnt3"}, 32'(rcnt3), 32'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        idle();
        step(); step();
        check_both("reset", 32'h0, 1'b0, 1'b0, 16'd0);
        check("reset.aerr", 32'(addr_err1), 32'd0);
        check("reset.pc_plus4", pc_plus4_1, 32'h4);
        rst = 1'b0;

        // Sequential fetch
        for (int i = 1; i <= 4; i++) begin
            step();
            check_both($sformatf("seq%0d", i), 32'(i * 4), 1'b0, 1'b0, 16'd0);
        end

        // j to 0xF4 so the branch test starts at 0x100
        drive(1'b1, 1'b1, OP_J, 6'd0, 1'b0, 16'd0, 26'h3D, 32'd0);
        step(); check_both("j_f4", 32'hF4, 1'b1, 1'b1, 16'd1);
        idle();
        step(); check_both("j_f4+1", 32'hF8, 1'b0, 1'b1, 16'd1);
        step(); check_both("j_f4+2", 32'hFC, 1'b0, 1'b1, 16'd1);
        step(); check_both("j_f4+3", 32'h100, 1'b0, 1'b0, 16'd1);

        // Taken beq backwards by 4 words
        drive(1'b1, 1'b1, OP_BEQ, 6'd0, 1'b1, 16'hFFFC, 26'd0, 32'd0);
        step(); check_both("beq_t", 32'hF4, 1'b1, 1'b1, 16'd2);
        idle();
        step(); check_both("beq_t+1", 32'hF8, 1'b0, 1'b1, 16'd2);
        step(); step(); check_both("beq_t+3", 32'h100, 1'b0, 1'b0, 16'd2);

        // Not-taken beq, then taken beq with instr_valid low
        drive(1'b1, 1'b1, OP_BEQ, 6'd0, 1'b0, 16'hFFFC, 26'd0, 32'd0);
        step(); check_both("beq_nt", 32'h104, 1'b0, 1'b0, 16'd2);
        drive(1'b0, 1'b0, OP_BEQ, 6'd0, 1'b1, 16'hFFFC, 26'd0, 32'd0);
        step(); check_both("beq_inv", 32'h108, 1'b0, 1'b0, 16'd2);

        // jr into the 0x3xxx_xxxx segment
        drive(1'b1, 1'b1, OP_RTYPE, FUNCT_JR, 1'b0, 16'd0, 26'd0, 32'h3000_0004);
        step(); check_both("jr_seg", 32'h3000_0004, 1'b1, 1'b1, 16'd3);
        check("jr_seg.aerr", 32'(addr_err1), 32'd0);
        idle();
        step(); step(); step();
        check_both("jr_seg+3", 32'h3000_0010, 1'b0, 1'b0, 16'd3);

        // j keeps pc_plus4[31:28]; control op during the 3-cycle window is ignored
        drive(1'b1, 1'b1, OP_J, 6'd0, 1'b0, 16'd0, 26'h40, 32'd0);
        step(); check_both("j_seg", 32'h3000_0100, 1'b1, 1'b1, 16'd4);
        drive(1'b0, 1'b1, OP_J, 6'd0, 1'b0, 16'd0, 26'h80, 32'd0);
        step(); check_both("j_ign1", 32'h3000_0104, 1'b0, 1'b1, 16'd4);
        step(); check_both("j_ign2", 32'h3000_0108, 1'b0, 1'b1, 16'd4);
        idle();
        step(); check_both("j_ign3", 32'h3000_010C, 1'b0, 1'b0, 16'd4);

        // Misaligned jr goes to the exception vector
        drive(1'b1, 1'b1, OP_RTYPE, FUNCT_JR, 1'b0, 16'd0, 26'd0, 32'h0000_2002);
        step(); check_both("jr_mis", 32'h80, 1'b1, 1'b1, 16'd5);
        check("jr_mis.aerr1", 32'(addr_err1), 32'd1);
        check("jr_mis.aerr3", 32'(addr_err3), 32'd1);
        idle();
        step(); check_both("jr_mis+1", 32'h84, 1'b0, 1'b1, 16'd5);
        check("jr_mis+1.aerr1", 32'(addr_err1), 32'd0);
        step(); step();

        // Aligned jr
        drive(1'b1, 1'b1, OP_RTYPE, FUNCT_JR, 1'b0, 16'd0, 26'd0, 32'h0000_2000);
        step(); check_both("jr_ok", 32'h2000, 1'b1, 1'b1, 16'd6);
        check("jr_ok.aerr", 32'(addr_err1), 32'd0);
        idle();
        step(); step(); step();

        // Misaligned jr then stall for 3 cycles inside the flush window
        drive(1'b1, 1'b1, OP_RTYPE, FUNCT_JR, 1'b0, 16'd0, 26'd0, 32'h0000_2003);
        step(); check_both("stl_jr", 32'h80, 1'b1, 1'b1, 16'd7);
        idle();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_both($sformatf("stl%0d", i), 32'h80, 1'b1, 1'b1, 16'd7);
            check($sformatf("stl%0d.aerr", i), 32'(addr_err1), 32'd0);
        end
        stall = 1'b0;
        step(); check_both("stl_rel1", 32'h84, 1'b0, 1'b1, 16'd7);
        step(); check_both("stl_rel2", 32'h88, 1'b0, 1'b1, 16'd7);
        step(); check_both("stl_rel3", 32'h8C, 1'b0, 1'b0, 16'd7);

        // Reset wins over stall while in REDIRECT
        drive(1'b1, 1'b1, OP_BEQ, 6'd0, 1'b1, 16'h0000, 26'd0, 32'd0);
        step(); check_both("rst_pre", 32'h90, 1'b1, 1'b1, 16'd8);
        idle();
        rst = 1'b1; stall = 1'b1;
        step(); check_both("rst_redir", 32'h0, 1'b0, 1'b0, 16'd0);
        rst = 1'b0; stall = 1'b0;

        // redirect_cnt wrap: branch to pc-4 so pc returns to 0 after each flush cycle
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 1'b0, OP_BEQ, 6'd0, 1'b1, 16'hFFFE, 26'd0, 32'd0);
            step();
            valid1 = 1'b0;
            step();
        end
        check("wrap_pre.cnt1", 32'(rcnt1), 32'h0000_FFFF);
        check("wrap_pre.pc1", pc1, 32'h0);
        drive(1'b1, 1'b0, OP_BEQ, 6'd0, 1'b1, 16'hFFFE, 26'd0, 32'd0);
        step();
        check("wrap.cnt1", 32'(rcnt1), 32'h0);
        check("wrap.pc1", pc1, 32'hFFFF_FFFC);
        check("wrap.flush1", 32'(flush1), 32'd1);
        check("wrap.cnt3", 32'(rcnt3), 32'h0);
        idle();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
